// File: rtl/program_memory.sv
// program_memory: 256x8 program store filled from a byte-stream loader
// (length byte, then data bytes), then served to the processor.
// Ports: clk, resetN (async, active-low); addr/strobe/dataRead = CPU read
// port, one-cycle latency; loadData/loadValid/loadReady = loader stream;
// reload = restart loading from RUN; loadDone/cpuResetN = program ready;
// loadError = one-cycle pulse on checksum mismatch.
// Optional feature macro: PROGRAM_MEMORY_CHECKSUM_EN adds a trailing
// checksum byte (LOAD_SUM state); without it loadError is tied low.
module program_memory (
   input  logic       clk,
   input  logic       resetN,
   input  logic [7:0] addr,
   input  logic       strobe,
   output logic [7:0] dataRead,
   input  logic [7:0] loadData,
   input  logic       loadValid,
   output logic       loadReady,
   input  logic       reload,
   output logic       loadDone,
   output logic       loadError,
   output logic       cpuResetN
);

`ifdef PROGRAM_MEMORY_CHECKSUM_EN
   typedef enum logic [1:0] {
      LOAD_LEN  = 2'd0,
      LOAD_DATA = 2'd1,
      LOAD_SUM  = 2'd2,
      RUN       = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      LOAD_LEN  = 2'd0,
      LOAD_DATA = 2'd1,
      RUN       = 2'd3
   } state_t;
`endif

   state_t     state;
   state_t     nextState;
   logic [7:0] mem [256];
   logic [7:0] ptr;
   logic [8:0] count;
   logic       xfer;
   logic       memWe;
   logic       goRun;

`ifdef PROGRAM_MEMORY_CHECKSUM_EN
   logic [7:0] sum;
   logic [7:0] sumChk;
   logic       errNext;
   assign sumChk = sum + loadData;
`endif

   assign xfer = loadValid & loadReady;

   // Next-state and decoded outputs
   always_comb begin
      nextState = state;
      memWe     = 1'b0;
      loadReady = 1'b1;
`ifdef PROGRAM_MEMORY_CHECKSUM_EN
      errNext   = 1'b0;
`endif
      unique case (state)
         LOAD_LEN: begin
            if (xfer)
               nextState = LOAD_DATA;
         end
         LOAD_DATA: begin
            if (xfer) begin
               memWe = 1'b1;
               // last data byte: counter about to hit zero
               if (count == 9'd1) begin
`ifdef PROGRAM_MEMORY_CHECKSUM_EN
                  nextState = LOAD_SUM;
`else
                  nextState = RUN;
`endif
               end
            end
         end
`ifdef PROGRAM_MEMORY_CHECKSUM_EN
         LOAD_SUM: begin
            if (xfer) begin
               if (sumChk == 8'h00) begin
                  nextState = RUN;
               end else begin
                  nextState = LOAD_LEN;
                  errNext   = 1'b1;
               end
            end
         end
`endif
         RUN: begin
            loadReady = 1'b0;
            if (reload)
               nextState = LOAD_LEN;
         end
         default: begin
            nextState = LOAD_LEN;
         end
      endcase
   end

   assign goRun = (nextState == RUN);

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN)
         state <= LOAD_LEN;
      else
         state <= nextState;
   end

   // Loader datapath, status flags and CPU read register
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         ptr       <= 8'h00;
         count     <= 9'd0;
         dataRead  <= 8'h00;
         loadDone  <= 1'b0;
         cpuResetN <= 1'b0;
`ifdef PROGRAM_MEMORY_CHECKSUM_EN
         sum       <= 8'h00;
         loadError <= 1'b0;
`endif
      end else begin
         loadDone  <= goRun;
         cpuResetN <= goRun;
`ifdef PROGRAM_MEMORY_CHECKSUM_EN
         loadError <= errNext;
`endif
         if (state == LOAD_LEN) begin
`ifdef PROGRAM_MEMORY_CHECKSUM_EN
            sum <= 8'h00;
`endif
            if (xfer) begin
               // a length byte of zero means a full 256-byte image
               count <= (loadData == 8'h00) ?
                        9'd256 : {1'b0, loadData};
               ptr   <= 8'h00;
            end
         end
         if (state == LOAD_DATA && xfer) begin
            ptr   <= ptr + 8'd1;
            count <= count - 9'd1;
`ifdef PROGRAM_MEMORY_CHECKSUM_EN
            sum   <= sumChk;
`endif
         end
         // reload wins over a same-edge read
         if (state == RUN && strobe && !reload)
            dataRead <= mem[addr];
      end
   end

`ifndef PROGRAM_MEMORY_CHECKSUM_EN
   assign loadError = 1'b0;
`endif

   // Storage array is deliberately not reset
   always_ff @(posedge clk) begin
      if (memWe)
         mem[ptr] <= loadData;
   end

endmodule

// File: doc/program_memory.md
PROGRAM_MEMORY -- requirements
Module: program_memory

Interface
REQ-001 The block SHALL provide these ports:
- clk  in  1  sole clock; all state changes on its rising edge
- resetN  in  1  asynchronous, active-low reset
- addr  in  8  processor read address
- strobe  in  1  processor read request
- dataRead  out  8  read data
- loadData  in  8  loader byte stream data
- loadValid  in  1  loader byte valid
- loadReady  out  1  block accepts loader byte
- reload  in  1  synchronous request to restart loading
- loadDone  out  1  program loaded; memory serving processor
- loadError  out  1  one-cycle pulse on checksum mismatch
- cpuResetN  out  1  active-low reset to processor

REQ-002 The reset polarity and synchronicity SHALL be fixed: one clock; reset is asynchronous and active-low.

REQ-003 There SHALL be no parameters; the storage is 256 x 8 bits.

Function
REQ-004 The state machine SHALL have the states LOAD_LEN, LOAD_DATA, LOAD_SUM (present only with the macro) and RUN.

REQ-005 A byte transfer SHALL occur on a rising edge where loadValid=1 and loadReady=1.

REQ-006 loadReady SHALL be decoded from the state: 1 in LOAD_LEN, LOAD_DATA and LOAD_SUM, and 0 in RUN.

REQ-007 In LOAD_LEN, a transfer SHALL latch the length L into a 9-bit remaining counter, with L=0 meaning 256.
- The write pointer SHALL be cleared to 0.
- The state SHALL go to LOAD_DATA.

REQ-008 In LOAD_DATA, each transfer SHALL write loadData to memory at the pointer, increment the pointer (8-bit, wraps after FF) and decrement the counter.

REQ-009 When the transfer that brings the counter to 0 completes, the state SHALL go to LOAD_SUM if the macro is defined, otherwise to RUN.

REQ-010 Cycles with loadValid=0 SHALL leave all load state unchanged, with no timeout.

REQ-011 RUN behaviour:
- loadDone=1 and cpuResetN=1; both are registered and go high on the first cycle in RUN.
- If strobe=1 on an edge, dataRead SHALL take mem[addr] on that edge, giving one-cycle read latency.
- If strobe=0, dataRead SHALL hold its value.

REQ-012 Outside RUN, strobe SHALL be ignored, dataRead SHALL hold its value, and loadDone=0 and cpuResetN=0.

REQ-013 reload=1 on an edge while in RUN SHALL move the state to LOAD_LEN, with cpuResetN=0 and loadDone=0 from the next cycle.
- If strobe=1 on the same edge, reload SHALL win and dataRead SHALL be unchanged.
- reload SHALL be ignored outside RUN.

REQ-014 Memory contents SHALL be retained across reload and are undefined after power-up until written.

Reset
REQ-015 While resetN=0, the outputs SHALL be asynchronously forced to:
- state=LOAD_LEN, so loadReady=1
- dataRead=00
- loadDone=0
- loadError=0
- cpuResetN=0
- pointer=0 and counter=0

REQ-016 Reset asserted mid-load SHALL abort the load immediately, and the next load SHALL start with a length byte.

REQ-017 The memory array SHALL NOT be reset.

Configuration
REQ-018 The checksum feature SHALL be compiled in or out by the macro PROGRAM_MEMORY_CHECKSUM_EN.

REQ-019 With PROGRAM_MEMORY_CHECKSUM_EN defined:
- A running 8-bit sum of data bytes SHALL be cleared in LOAD_LEN.
- In LOAD_SUM, one transfer SHALL be accepted.
- If (sum + byte) mod 256 = 0, the state SHALL go to RUN.
- Otherwise the state SHALL go to LOAD_LEN and loadError SHALL be 1 for exactly the following cycle.

REQ-020 Without PROGRAM_MEMORY_CHECKSUM_EN:
- LOAD_SUM and the sum register SHALL be absent.
- loadError SHALL be tied to 0.
- The state SHALL go directly from LOAD_DATA to RUN.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Basic load (no macro): stream 03 AA BB CC -> cpuResetN=1 and loadDone=1 the cycle after the 4th transfer; then strobe with addr=01 -> dataRead=BB one cycle later.
- Length 0: stream 00 then 256 bytes equal to their index -> RUN only after byte 256; strobe addr=FF -> dataRead=FF; strobe addr=00 -> dataRead=00.
- Backpressure and ignored reads: loadValid toggles 1,0,0,1 during LOAD_DATA -> only valid cycles are written; strobe=1 during load -> dataRead stays 00.
- Reload collision: in RUN, reload=1 and strobe=1 on the same edge -> state LOAD_LEN, dataRead unchanged, loadReady=1, cpuResetN=0; reload new program 01 5A -> addr 00 reads 5A.
- Reset mid-load: resetN pulsed low after 2 of 4 data bytes -> all outputs at reset values without a clock edge; fresh load 01 77 succeeds.
- Checksum (macro defined): 02 10 20 D0 -> RUN; 02 10 20 D1 -> loadError pulse of one cycle, state LOAD_LEN, cpuResetN stays 0.
